// File: rtl/addsub_rr_sched.sv
// addsub_rr_sched: round-robin sharing of one 8-bit add/sub unit.
// Define ADDSUB_SAT_EN to clamp overflowed results to 7F/80.

module addsub8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       m,
  output logic [7:0] s,
  output logic       ovf
);
  logic [7:0] bx;
  logic [7:0] lo;
  logic [1:0] hi;

  // low 7 bits give carry into MSB, top bit gives carry out
  always_comb begin
    bx  = b ^ {8{m}};
    lo  = {1'b0, a[6:0]} + {1'b0, bx[6:0]} + {7'd0, m};
    hi  = {1'b0, a[7]} + {1'b0, bx[7]} + {1'b0, lo[7]};
    s   = {hi[0], lo[6:0]};
    ovf = lo[7] ^ hi[1];
  end
endmodule

module addsub_rr_sched #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [8*NREQ-1:0]       req_a,
  input  logic [8*NREQ-1:0]       req_b,
  input  logic [NREQ-1:0]         req_m,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [7:0]              rsp_s,
  output logic                    rsp_ovf,
  output logic [7:0]              ovf_cnt
);
  localparam int IDW = $clog2(NREQ);

  logic           op_v_q, op_v_d;
  logic [7:0]     op_a_q, op_a_d;
  logic [7:0]     op_b_q, op_b_d;
  logic           op_m_q, op_m_d;
  logic [IDW-1:0] op_id_q, op_id_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [7:0]     rsp_s_q, rsp_s_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]     ovf_cnt_q, ovf_cnt_d;
  logic [IDW-1:0] last_grant_q, last_grant_d;

  logic           res_adv;
  logic           op_adv;
  logic           accept;
  logic           found;
  logic [IDW-1:0] idx;
  logic [IDW-1:0] grant;
  logic [7:0]     alu_s;
  logic           alu_ovf;
  logic [7:0]     res_s;

  addsub8 u_alu (
    .a   (op_a_q),
    .b   (op_b_q),
    .m   (op_m_q),
    .s   (alu_s),
    .ovf (alu_ovf)
  );

  // round-robin scan starting after the last grant
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = last_grant_q;
    for (int k = 0; k < NREQ; k++) begin
      if (idx == IDW'(NREQ - 1)) idx = '0;
      else                       idx = idx + 1'b1;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  // pipeline advance, operand/result loading and overflow counting
  always_comb begin
    res_adv = !rsp_valid_q | rsp_ready;
    op_adv  = op_v_q & res_adv;
    accept  = (!op_v_q | op_adv) & found & !rst;

    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;

    res_s = alu_s;
`ifdef ADDSUB_SAT_EN
    if (alu_ovf) res_s = op_a_q[7] ? 8'h80 : 8'h7F;
`endif

    op_v_d       = op_v_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_m_d       = op_m_q;
    op_id_d      = op_id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      op_v_d       = 1'b1;
      op_id_d      = grant;
      last_grant_d = grant;
      for (int i = 0; i < NREQ; i++) begin
        if (grant == IDW'(i)) begin
          op_a_d = req_a[8*i +: 8];
          op_b_d = req_b[8*i +: 8];
          op_m_d = req_m[i];
        end
      end
    end else if (op_adv) begin
      op_v_d = 1'b0;
    end

    rsp_valid_d = rsp_valid_q;
    rsp_s_d     = rsp_s_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_id_d    = rsp_id_q;
    if (op_adv) begin
      rsp_valid_d = 1'b1;
      rsp_s_d     = res_s;
      rsp_ovf_d   = alu_ovf;
      rsp_id_d    = op_id_q;
    end else if (res_adv) begin
      rsp_valid_d = 1'b0;
    end

    ovf_cnt_d = ovf_cnt_q;
    if (rsp_valid_q && rsp_ready && rsp_ovf_q && ovf_cnt_q != 8'hFF)
      ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      op_v_q       <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_m_q       <= 1'b0;
      op_id_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_s_q      <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_id_q     <= '0;
      ovf_cnt_q    <= '0;
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      op_v_q       <= op_v_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_m_q       <= op_m_d;
      op_id_q      <= op_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_s_q      <= rsp_s_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_id_q     <= rsp_id_d;
      ovf_cnt_q    <= ovf_cnt_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_id    = rsp_id_q;
  assign ovf_cnt   = ovf_cnt_q;
endmodule

// File: tb/tb_addsub_rr_sched.sv
// tb_addsub_rr_sched: vectors, directed sequences and a
// reference FIFO model for addsub_rr_sched.

module tb_addsub_rr_sched;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [N-1:0] req_ready;
  logic [8*N-1:0] req_a;
  logic [8*N-1:0] req_b;
  logic [N-1:0] req_m;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_s;
  logic         rsp_ovf;
  logic [7:0]   ovf_cnt;

  logic [7:0] opa [N];
  logic [7:0] opb [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic       m;
    logic [7:0] s;
    logic       ovf;
  } vec_t;

  typedef struct {
    int         id;
    logic [7:0] s;
    logic       ovf;
    int         edge_n;
  } item_t;

  item_t q[$];
  int    got_ids[$];
  int    rr;
  int    cnt;
  int    edge_n;

  addsub_rr_sched #(.NREQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_m     (req_m),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_s     (rsp_s),
    .rsp_ovf   (rsp_ovf),
    .ovf_cnt   (ovf_cnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = {opa[3], opa[2], opa[1], opa[0]};
    req_b = {opb[3], opb[2], opb[1], opb[0]};
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // signed-integer reference of the add/sub unit
  function automatic void ref_op(input logic [7:0] a, input logic [7:0] b,
                                 input logic m, output logic [7:0] s,
                                 output logic ovf);
    int sa, sb, r;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = m ? sa - sb : sa + sb;
    ovf = (r > 127) || (r < -128);
    s   = r[7:0];
`ifdef ADDSUB_SAT_EN
    if (ovf) s = a[7] ? 8'h80 : 8'h7F;
`endif
  endfunction

  function automatic logic [7:0] sat_of(input logic [7:0] a,
                                        input logic [7:0] s,
                                        input logic ovf);
`ifdef ADDSUB_SAT_EN
    if (ovf) return a[7] ? 8'h80 : 8'h7F;
`endif
    return s;
  endfunction

  task automatic model_init();
    q.delete();
    rr     = N - 1;
    cnt    = 0;
    edge_n = 0;
  endtask

  // one clock: compare DUT with the model, then advance both
  task automatic cycle();
    logic [N-1:0] er;
    logic         ev;
    int           g;
    int           idx;
    logic [7:0]   ps;
    logic         po;
    #1;
    er = '0;
    g  = -1;
    if (!rst && req_valid != 0 && (q.size() < 2 || rsp_ready)) begin
      for (int k = 1; k <= N; k++) begin
        idx = (rr + k) % N;
        if (g < 0 && ((req_valid >> idx) & 1) != 0) g = idx;
      end
      er = N'(1 << g);
    end
    ev = (q.size() > 0) && (q[0].edge_n < edge_n);
    chk("req_ready", 32'(req_ready), 32'(er));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_s", 32'(rsp_s), 32'(q[0].s));
      chk("rsp_ovf", 32'(rsp_ovf), 32'(q[0].ovf));
    end
    chk("ovf_cnt", 32'(ovf_cnt), 32'(cnt));
    ps = '0;
    po = 1'b0;
    if (g >= 0) ref_op(opa[g], opb[g], ((req_m >> g) & 1) != 0, ps, po);
    @(posedge clk);
    edge_n++;
    if (rst) begin
      q.delete();
      cnt = 0;
      rr  = N - 1;
    end else begin
      if (ev && rsp_ready) begin
        got_ids.push_back(q[0].id);
        if (q[0].ovf && cnt < 255) cnt++;
        void'(q.pop_front());
      end
      if (g >= 0) begin
        q.push_back('{id: g, s: ps, ovf: po, edge_n: edge_n});
        rr = g;
      end
    end
    #1;
  endtask

  task automatic set_all(input logic [7:0] a, input logic [7:0] b,
                         input logic m);
    for (int i = 0; i < N; i++) begin
      opa[i] = a;
      opb[i] = b;
    end
    req_m = {N{m}};
  endtask

  vec_t vt[8];
  int   exp_cnt;

  initial begin
    vt[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b0};
    vt[1] = '{1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b1};
    vt[2] = '{2, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1};
    vt[3] = '{2, 8'h6C, 8'hCA, 1'b1, 8'hA2, 1'b1};
    vt[4] = '{3, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vt[5] = '{0, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0};
    vt[6] = '{1, 8'hC0, 8'h40, 1'b1, 8'h80, 1'b0};
    vt[7] = '{3, 8'h7F, 8'h80, 1'b1, 8'hFF, 1'b1};

    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    set_all(8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst req_ready", 32'(req_ready), 32'h0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst rsp_id", 32'(rsp_id), 32'h0);
    chk("rst rsp_s", 32'(rsp_s), 32'h0);
    chk("rst rsp_ovf", 32'(rsp_ovf), 32'h0);
    chk("rst ovf_cnt", 32'(ovf_cnt), 32'h0);
    rst = 1'b0;
    #1;
    chk("first grant", 32'(req_ready), 32'h1);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;

    exp_cnt = 0;
    for (int v = 0; v < 8; v++) begin
      opa[vt[v].id] = vt[v].a;
      opb[vt[v].id] = vt[v].b;
      req_m         = N'(vt[v].m) << vt[v].id;
      req_valid     = N'(1) << vt[v].id;
      #1;
      chk("vec req_ready", 32'(req_ready), 32'(1 << vt[v].id));
      @(posedge clk); #1;
      req_valid = '0;
      @(posedge clk); #1;
      chk("vec rsp_valid", 32'(rsp_valid), 32'h1);
      chk("vec rsp_id", 32'(rsp_id), 32'(vt[v].id));
      chk("vec rsp_s", 32'(rsp_s),
          32'(sat_of(vt[v].a, vt[v].s, vt[v].ovf)));
      chk("vec rsp_ovf", 32'(rsp_ovf), 32'(vt[v].ovf));
      @(posedge clk); #1;
      if (vt[v].ovf) exp_cnt++;
      chk("vec ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt));
      chk("vec drained", 32'(rsp_valid), 32'h0);
    end

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_init();

    // all requesters valid with a free consumer
    for (int i = 0; i < N; i++) begin
      opa[i] = 8'(i * 16 + 3);
      opb[i] = 8'(i + 1);
    end
    req_m = 4'b1010;
    req_valid = '1;
    rsp_ready = 1'b1;
    got_ids.delete();
    for (int c = 0; c < 12; c++) cycle();
    chk("rr count", 32'(got_ids.size() >= 8), 32'h1);
    for (int k = 0; k < 8 && k < got_ids.size(); k++)
      chk("rr order", 32'(got_ids[k]), 32'(k % N));

    // stalled consumer with requesters 0 and 1
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    req_valid = 4'b0011;
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) cycle();
    #1;
    chk("stall req_ready", 32'(req_ready), 32'h0);
    chk("stall rsp_id", 32'(rsp_id), 32'h0);
    req_valid = '0;
    rsp_ready = 1'b1;
    got_ids.delete();
    for (int c = 0; c < 4; c++) cycle();
    chk("drain count", 32'(got_ids.size()), 32'h2);
    if (got_ids.size() == 2) begin
      chk("drain id0", 32'(got_ids[0]), 32'h0);
      chk("drain id1", 32'(got_ids[1]), 32'h1);
    end

    // reset with both stages full
    set_all(8'h7F, 8'h01, 1'b0);
    req_valid = 4'b0110;
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("post rst rsp_valid", 32'(rsp_valid), 32'h0);
    chk("post rst ovf_cnt", 32'(ovf_cnt), 32'h0);
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    chk("post rst grant", 32'(req_ready), 32'h1);
    for (int c = 0; c < 4; c++) cycle();

    // long overflow run to reach counter saturation
    for (int c = 0; c < 262; c++) cycle();
    chk("ovf_cnt saturate", 32'(ovf_cnt), 32'hFF);

    // randomized traffic, backpressure and occasional reset
    for (int c = 0; c < 500; c++) begin
      req_valid = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        opa[i] = 8'($urandom);
        opb[i] = 8'($urandom);
      end
      req_m     = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 63) == 0);
      cycle();
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
